// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Operands are captured in IDLE, special cases are resolved in CHECK, normal
// operands go through a 24-cycle shift-add significand multiply, then
// normalise, round and finally publish the result and flags in DONE.
module fp_mul_seq #(
  parameter int unsigned ROUND_NEAREST = 1  // 1: round-to-nearest-even, 0: truncate
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exponent_a,
  input  logic [7:0]  exponent_b,
  input  logic [22:0] mantissa_a,
  input  logic [22:0] mantissa_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {StIdle, StCheck, StMult, StNorm, StRound, StDone} state_e;

  state_e             state_q, state_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [7:0]         exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [22:0]        man_a_q, man_a_d, man_b_q, man_b_d;
  logic [47:0]        mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        prod_q, prod_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        sig_q, sig_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic               special_q, special_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic               spec_inv_q, spec_inv_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               invalid_q, invalid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  // Operand classification; exponent 0 covers both zero and denormal (flushed to zero).
  logic sign_r;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [24:0] sig_inc;

  assign sign_r = sign_a_q ^ sign_b_q;
  assign zero_a = (exp_a_q == 8'h00);
  assign zero_b = (exp_b_q == 8'h00);
  assign inf_a  = (exp_a_q == 8'hFF) && (man_a_q == 23'd0);
  assign inf_b  = (exp_b_q == 8'hFF) && (man_b_q == 23'd0);
  assign nan_a  = (exp_a_q == 8'hFF) && (man_a_q != 23'd0);
  assign nan_b  = (exp_b_q == 8'hFF) && (man_b_q != 23'd0);

  // Next-state and datapath logic for every FSM state.
  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_a_d     = man_a_q;
    man_b_d     = man_b_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    special_d   = special_q;
    spec_res_d  = spec_res_q;
    spec_inv_d  = spec_inv_q;
    done_d      = 1'b0;
    result_d    = result_q;
    invalid_d   = invalid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    sig_inc     = {1'b0, sig_q} + 25'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          exp_a_d  = exponent_a;
          exp_b_d  = exponent_b;
          man_a_d  = mantissa_a;
          man_b_d  = mantissa_b;
          state_d  = StCheck;
        end
      end

      StCheck: begin
        // Max 254+254-127 = 381, min 1+1-127 = -125: fits 10-bit signed without wrap.
        exp_d      = {2'b00, exp_a_q} + {2'b00, exp_b_q} - 10'd127;
        mcand_d    = {24'd0, 1'b1, man_a_q};
        mplier_d   = {1'b1, man_b_q};
        prod_d     = 48'd0;
        cnt_d      = 5'd0;
        special_d  = 1'b1;
        spec_inv_d = 1'b0;
        if (nan_a || nan_b) begin
          spec_res_d = 32'h7FC0_0000;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
          spec_res_d = 32'h7FC0_0000;
          spec_inv_d = 1'b1;
        end else if (inf_a || inf_b) begin
          spec_res_d = {sign_r, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
          spec_res_d = {sign_r, 31'd0};
        end else begin
          special_d  = 1'b0;
        end
        state_d = special_d ? StDone : StMult;
      end

      StMult: begin
        // One multiplier bit per cycle, LSB first, multiplicand shifted left.
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = StNorm;
      end

      StNorm: begin
        if (prod_q[47]) begin
          sig_d    = prod_q[47:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          sig_d    = prod_q[46:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = StRound;
      end

      StRound: begin
        if ((ROUND_NEAREST != 0) && guard_q && (sticky_q || sig_q[0])) begin
          if (sig_inc[24]) begin
            // All-ones significand rolled over: renormalise to 1.0 x 2^(e+1).
            sig_d = 24'h80_0000;
            exp_d = exp_q + 10'sd1;
          end else begin
            sig_d = sig_inc[23:0];
          end
        end
        state_d = StDone;
      end

      StDone: begin
        done_d      = 1'b1;
        invalid_d   = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (special_q) begin
          result_d  = spec_res_q;
          invalid_d = spec_inv_q;
        end else if (exp_q >= 10'sd255) begin
          result_d   = {sign_r, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else if (exp_q <= 10'sd0) begin
          result_d    = {sign_r, 31'd0};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_r, exp_q[7:0], sig_q[22:0]};
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sig_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      spec_inv_q  <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_a_q     <= man_a_d;
      man_b_q     <= man_b_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      special_q   <= special_d;
      spec_res_q  <= spec_res_d;
      spec_inv_q  <= spec_inv_d;
      done_q      <= done_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign result    = result_q;
  assign invalid   = invalid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: two instances (nearest-even and truncate)
// share stimulus; a reference model pushes expected results and latencies,
// per-instance monitors pop and compare whenever done is seen.
module tb_fp_mul_seq;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        unf;
    int          lat;
    int          cap;
  } exp_t;

  logic        clk, rst, start;
  logic        sign_a, sign_b;
  logic [7:0]  exponent_a, exponent_b;
  logic [22:0] mantissa_a, mantissa_b;

  logic        busy_rn, done_rn, inv_rn, ovf_rn, unf_rn;
  logic [31:0] res_rn;
  logic        busy_tr, done_tr, inv_tr, ovf_tr, unf_tr;
  logic [31:0] res_tr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_rn[$];
  exp_t q_tr[$];

  fp_mul_seq #(.ROUND_NEAREST(1)) u_rn (
    .clk(clk), .rst(rst), .start(start),
    .sign_a(sign_a), .sign_b(sign_b),
    .exponent_a(exponent_a), .exponent_b(exponent_b),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .busy(busy_rn), .done(done_rn), .result(res_rn),
    .invalid(inv_rn), .overflow(ovf_rn), .underflow(unf_rn)
  );

  fp_mul_seq #(.ROUND_NEAREST(0)) u_tr (
    .clk(clk), .rst(rst), .start(start),
    .sign_a(sign_a), .sign_b(sign_b),
    .exponent_a(exponent_a), .exponent_b(exponent_b),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .busy(busy_tr), .done(done_tr), .result(res_tr),
    .invalid(inv_tr), .overflow(ovf_tr), .underflow(unf_tr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference: exact integer product, then round by comparing the remainder with one half ULP.
  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rn);
    exp_t r;
    int ea, eb, e, sh;
    bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint unsigned ma, mb, p, m, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s = a[31] ^ b[31];
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    r.inv = 0; r.ovf = 0; r.unf = 0; r.lat = 2; r.cap = 0; r.res = 0;
    if (nan_a || nan_b) r.res = 32'h7FC0_0000;
    else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
      r.res = 32'h7FC0_0000;
      r.inv = 1;
    end else if (inf_a || inf_b) r.res = {s, 8'hFF, 23'h0};
    else if (zero_a || zero_b) r.res = {s, 31'h0};
    else begin
      r.lat = 28;
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      p = ma * mb;
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e++;
      end else sh = 23;
      m = p >> sh;
      rem = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rn && ((rem > half) || ((rem == half) && m[0]))) m++;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e++;
      end
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0};
        r.ovf = 1;
      end else if (e <= 0) begin
        r.res = {s, 31'h0};
        r.unf = 1;
      end else r.res = {s, 8'(e), m[22:0]};
    end
    return r;
  endfunction

  function automatic void push(input logic [31:0] a, input logic [31:0] b, input int cap);
    exp_t e;
    e = ref_mul(a, b, 1'b1);
    e.cap = cap;
    q_rn.push_back(e);
    e = ref_mul(a, b, 1'b0);
    e.cap = cap;
    q_tr.push_back(e);
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2: v[30:23] = 8'h00;
      3: begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = 23'h7FFFFF; end
      4: v[30:23] = 8'($urandom_range(1, 254));
      5: v[30:23] = 8'($urandom_range(180, 254));
      6: v[30:23] = 8'($urandom_range(1, 70));
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    sign_a = a[31]; exponent_a = a[30:23]; mantissa_a = a[22:0];
    sign_b = b[31]; exponent_b = b[30:23]; mantissa_b = b[22:0];
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(a, b);
    start = 1'b1;
    push(a, b, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q_rn.size() != 0 || q_tr.size() != 0); i++) @(negedge clk);
    checks++;
    if (q_rn.size() != 0 || q_tr.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: pending %0d/%0d results after 200 cycles",
               q_rn.size(), q_tr.size());
      q_rn.delete();
      q_tr.delete();
    end
  endtask

  // Scoreboard monitor for the nearest-even instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_rn) begin
      if (q_rn.size() == 0) begin
        checks++; errors++;
        $display("FAIL rn_unexpected_done: result %h with nothing outstanding", res_rn);
      end else begin
        e = q_rn.pop_front();
        check("rn_result", res_rn, e.res);
        check("rn_flags", {29'd0, inv_rn, ovf_rn, unf_rn}, {29'd0, e.inv, e.ovf, e.unf});
        check("rn_latency", 32'(cyc - e.cap), 32'(e.lat));
      end
    end
  end

  // Scoreboard monitor for the truncating instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_tr) begin
      if (q_tr.size() == 0) begin
        checks++; errors++;
        $display("FAIL tr_unexpected_done: result %h with nothing outstanding", res_tr);
      end else begin
        e = q_tr.pop_front();
        check("tr_result", res_tr, e.res);
        check("tr_flags", {29'd0, inv_tr, ovf_tr, unf_tr}, {29'd0, e.inv, e.ovf, e.unf});
        check("tr_latency", 32'(cyc - e.cap), 32'(e.lat));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [12];
  logic [31:0] dir_b [12];

  initial begin
    int cap1, lat1;
    logic [31:0] a, b, a2, b2;
    exp_t t;
    dir_a = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h7F800000, 32'h7F000000,
              32'h0D800000, 32'h7FC00001, 32'h7F800000, 32'h00000001, 32'h80000000,
              32'h3FFFFFFF, 32'h3F800000};
    dir_b = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h00000000, 32'h7F000000,
              32'h0D800000, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h40A00000,
              32'h3FFFFFFF, 32'h3F800003};
    rst = 1'b1;
    start = 1'b0;
    drive(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {30'd0, busy_rn, busy_tr}, 32'd0);
    check("reset_done", {30'd0, done_rn, done_tr}, 32'd0);
    check("reset_result_rn", res_rn, 32'd0);
    check("reset_result_tr", res_tr, 32'd0);
    check("reset_flags", {26'd0, inv_rn, ovf_rn, unf_rn, inv_tr, ovf_tr, unf_tr}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      issue(dir_a[i], dir_b[i]);
      drain();
    end

    // start held high across DONE: new inputs must only be taken on the first IDLE cycle.
    for (int j = 0; j < 20; j++) begin
      a = (j == 0) ? 32'h3FC00000 : rnd_op();
      b = (j == 0) ? 32'h40000000 : rnd_op();
      a2 = rnd_op();
      b2 = rnd_op();
      @(negedge clk);
      drive(a, b);
      start = 1'b1;
      cap1 = cyc + 1;
      push(a, b, cap1);
      t = ref_mul(a, b, 1'b1);
      lat1 = t.lat;
      @(negedge clk);
      drive(a2, b2);
      push(a2, b2, cap1 + lat1 + 1);
      repeat (lat1 + 1) @(negedge clk);
      start = 1'b0;
      drain();
    end

    // Reset at edge 10 of an operation aborts it silently.
    @(negedge clk);
    drive(32'h3FC00000, 32'h40000000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("abort_busy", {30'd0, busy_rn, busy_tr}, 32'd0);
    check("abort_result", res_rn, 32'd0);
    repeat (40) @(negedge clk);
    issue(32'hC0400000, 32'h3F000000);
    drain();

    // Randomised operands.
    for (int i = 0; i < 300; i++) begin
      issue(rnd_op(), rnd_op());
      drain();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
